// File: rtl/router6_port_arbiter.sv
// router6_port_arbiter
//   Grant scheduler for the three output merges (P, C1, C2) of the 3-port
//   router. Each output picks one of its two candidate inputs round-robin,
//   offers the winner's select token to the merge, then holds the grant
//   until the merge reports completion or the hold limit expires. The three
//   outputs run fully independently.
//
//   Ports
//     CLK        clock, rising edge
//     _RESET     asynchronous active-low reset
//     req[5:0]   level requests, bit 2*o+i = input i wants output o
//     req_ack    1-cycle pulse to requester 2*o+i on accepted grant
//     gnt_valid  per-output token valid
//     gnt_sel    per-output token value (0=In0, 1=In1)
//     gnt_ready  per-output token accept from the merge
//     done       per-output 1-cycle packet-complete pulse
//     timeout    per-output sticky hold-limit flag
//   All outputs are registered.

// Per-output scheduler: IDLE -> ISSUE (token offered) -> BUSY (held).
module router6_port_arbiter_lane #(
    parameter int HOLD_MAX = 255,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       gnt_ready,
    input  logic       done,
    output logic [1:0] req_ack,
    output logic       gnt_valid,
    output logic       gnt_sel,
    output logic       timeout
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             last;   // input granted on the most recent handshake

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            req_ack   <= 2'b00;
            gnt_valid <= 1'b0;
            gnt_sel   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            req_ack <= 2'b00;
            case (state)
                IDLE: begin
                    if (|req) begin
                        // Contention goes to whoever did not win last time.
                        gnt_sel   <= (req == 2'b11) ? ~last : req[1];
                        gnt_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Token is committed: a dropped request still waits
                    // for the merge to take it.
                    if (gnt_ready) begin
                        req_ack   <= gnt_sel ? 2'b10 : 2'b01;
                        last      <= gnt_sel;
                        cnt       <= '0;
                        gnt_valid <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // done has priority over an expiring hold on the same edge.
                    if (done) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        timeout <= 1'b1;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

module router6_port_arbiter #(
    parameter int HOLD_MAX = 255,
    parameter int CNT_W    = 8
) (
    input  logic       CLK,
    input  logic       _RESET,
    input  logic [5:0] req,
    output logic [5:0] req_ack,
    output logic [2:0] gnt_valid,
    output logic [2:0] gnt_sel,
    input  logic [2:0] gnt_ready,
    input  logic [2:0] done,
    output logic [2:0] timeout
);
    localparam int NUM_OUT = 3;

    for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
        router6_port_arbiter_lane #(
            .HOLD_MAX (HOLD_MAX),
            .CNT_W    (CNT_W)
        ) u_lane (
            .clk       (CLK),
            .rst_n     (_RESET),
            .req       (req[2*o +: 2]),
            .gnt_ready (gnt_ready[o]),
            .done      (done[o]),
            .req_ack   (req_ack[2*o +: 2]),
            .gnt_valid (gnt_valid[o]),
            .gnt_sel   (gnt_sel[o]),
            .timeout   (timeout[o])
        );
    end
endmodule

// File: tb/tb_router6_port_arbiter.sv
// Directed bench for router6_port_arbiter with a per-cycle reference model
// and hand-computed expectations for the key scenarios.
module tb_router6_port_arbiter;
    localparam int HOLD = 4;

    logic       CLK;
    logic       _RESET;
    logic [5:0] req;
    logic [5:0] req_ack;
    logic [2:0] gnt_valid;
    logic [2:0] gnt_sel;
    logic [2:0] gnt_ready;
    logic [2:0] done;
    logic [2:0] timeout;

    int vectors     = 0;
    int miscompares = 0;

    router6_port_arbiter #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
        .CLK       (CLK),
        ._RESET    (_RESET),
        .req       (req),
        .req_ack   (req_ack),
        .gnt_valid (gnt_valid),
        .gnt_sel   (gnt_sel),
        .gnt_ready (gnt_ready),
        .done      (done),
        .timeout   (timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // ---------------- reference model ----------------
    // tok: input whose token is on offer (-1 = none)
    // hold_left: remaining cycles of an accepted grant (0 = not holding)
    // pref: input that wins the next contention
    int         tok[3];
    int         hold_left[3];
    int         pref[3];
    logic [5:0] m_ack;
    logic [2:0] m_sel;
    logic [2:0] m_to;

    always @(posedge CLK or negedge _RESET) begin : mdl
        int         t, h, p;
        logic [5:0] a;
        logic [2:0] s, to;
        if (!_RESET) begin
            for (int o = 0; o < 3; o++) begin
                tok[o]       <= -1;
                hold_left[o] <= 0;
                pref[o]      <= 0;
            end
            m_ack <= '0;
            m_sel <= '0;
            m_to  <= '0;
        end else begin
            a  = '0;
            s  = m_sel;
            to = m_to;
            for (int o = 0; o < 3; o++) begin
                t = tok[o];
                h = hold_left[o];
                p = pref[o];
                if (h > 0) begin
                    if (done[o]) h = 0;
                    else if (h == 1) begin
                        h = 0;
                        to[o] = 1'b1;
                    end else h = h - 1;
                end else if (t >= 0) begin
                    if (gnt_ready[o]) begin
                        a[2*o + t] = 1'b1;
                        p = 1 - t;
                        h = HOLD;
                        t = -1;
                    end
                end else begin
                    if (req[2*o] && req[2*o+1]) t = p;
                    else if (req[2*o]) t = 0;
                    else if (req[2*o+1]) t = 1;
                    if (t >= 0) s[o] = (t == 1);
                end
                tok[o]       <= t;
                hold_left[o] <= h;
                pref[o]      <= p;
            end
            m_ack <= a;
            m_sel <= s;
            m_to  <= to;
        end
    end

    // One compare per output group on every cycle once out of the first reset.
    always @(negedge CLK) begin
        logic [2:0] ev;
        if ($time > 20) begin
            for (int o = 0; o < 3; o++) ev[o] = (tok[o] >= 0);
            check("mdl_gnt_valid", {5'b0, gnt_valid}, {5'b0, ev});
            check("mdl_gnt_sel",   {5'b0, gnt_sel},   {5'b0, m_sel});
            check("mdl_req_ack",   {2'b0, req_ack},   {2'b0, m_ack});
            check("mdl_timeout",   {5'b0, timeout},   {5'b0, m_to});
        end
    end

    task automatic do_reset();
        _RESET = 1'b0;
        req = '0; gnt_ready = '0; done = '0;
        tick(2);
        _RESET = 1'b1;
        tick(1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int   k;
        logic stable;
        logic rr[4];

        _RESET = 1'b0;
        req = '0; gnt_ready = '0; done = '0;
        tick(2);
        _RESET = 1'b1;
        check("rst_valid", {5'b0, gnt_valid}, 8'h00);
        check("rst_sel",   {5'b0, gnt_sel},   8'h00);
        check("rst_ack",   {2'b0, req_ack},   8'h00);
        check("rst_to",    {5'b0, timeout},   8'h00);

        // reset while a token is on offer
        req = 6'b000001;
        tick(1);
        check("issue_valid", {5'b0, gnt_valid}, 8'h01);
        tick(1);
        #2 _RESET = 1'b0;
        #1;
        check("async_rst_valid", {5'b0, gnt_valid}, 8'h00);
        check("async_rst_ack",   {2'b0, req_ack},   8'h00);
        req = '0;
        tick(1);
        _RESET = 1'b1;
        tick(1);
        check("post_rst_idle", {5'b0, gnt_valid}, 8'h00);

        // single request, ready already high
        req = 6'b000001; gnt_ready = 3'b001;
        tick(1);
        check("single_valid", {7'b0, gnt_valid[0]}, 8'h01);
        check("single_sel",   {7'b0, gnt_sel[0]},   8'h00);
        check("single_noack", {2'b0, req_ack},      8'h00);
        tick(1);
        check("single_ack", {2'b0, req_ack}, 8'h01);
        req = '0;
        tick(1);
        check("single_ack_once", {2'b0, req_ack},   8'h00);
        check("single_busy",     {5'b0, gnt_valid}, 8'h00);
        done = 3'b001;
        tick(1);
        done = '0;
        tick(2);

        // round-robin on P, both inputs requesting
        do_reset();
        req = 6'b000011; gnt_ready = 3'b001;
        for (int g = 0; g < 4; g++) begin
            k = 0;
            while (req_ack[1:0] == 2'b00 && k < 20) begin
                tick(1);
                k++;
            end
            check("rr_wait", {7'b0, k < 20}, 8'h01);
            rr[g] = req_ack[1];
            if (g == 3) req = '0;
            tick(2);
            done = 3'b001;
            tick(1);
            done = '0;
        end
        check("rr_0", {7'b0, rr[0]}, 8'h00);
        check("rr_1", {7'b0, rr[1]}, 8'h01);
        check("rr_2", {7'b0, rr[2]}, 8'h00);
        check("rr_3", {7'b0, rr[3]}, 8'h01);
        tick(2);

        // backpressure on C1, with request drop and stray done in ISSUE
        do_reset();
        req = 6'b000100;
        tick(1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            done = (i == 3) ? 3'b010 : 3'b000;
            if (i == 5) req = '0;
            tick(1);
            stable &= (gnt_valid[1] == 1'b1) && (gnt_sel[1] == 1'b0) && (req_ack == 6'b0);
        end
        done = '0;
        check("bp_stable", {7'b0, stable}, 8'h01);
        gnt_ready = 3'b010;
        tick(1);
        check("bp_ack", {2'b0, req_ack}, 8'h04);
        gnt_ready = '0;
        tick(1);
        check("bp_ack_once", {2'b0, req_ack}, 8'h00);
        done = 3'b010;
        tick(1);
        done = '0;
        tick(2);

        // timeout on C2
        do_reset();
        req = 6'b010000; gnt_ready = 3'b100;
        tick(2);
        check("to_ack", {2'b0, req_ack}, 8'h10);
        req = '0;
        tick(3);
        check("to_early", {5'b0, timeout}, 8'h00);
        tick(1);
        check("to_set",   {5'b0, timeout},   8'h04);
        check("to_idle",  {5'b0, gnt_valid}, 8'h00);
        tick(3);
        check("to_sticky", {5'b0, timeout}, 8'h04);
        check("to_noack",  {2'b0, req_ack}, 8'h00);

        // done on the same edge the hold would expire: done wins
        req = 6'b000001; gnt_ready = 3'b101;
        tick(2);
        check("tie_ack", {2'b0, req_ack}, 8'h01);
        req = '0;
        tick(3);
        done = 3'b001;
        tick(1);
        done = '0;
        check("tie_no_to", {5'b0, timeout}, 8'h04);
        tick(2);

        // all three outputs in parallel
        do_reset();
        req = 6'b111111; gnt_ready = 3'b111;
        tick(1);
        check("par_valid", {5'b0, gnt_valid}, 8'h07);
        check("par_sel",   {5'b0, gnt_sel},   8'h00);
        tick(1);
        check("par_ack", {2'b0, req_ack}, 8'h15);
        tick(1);
        done = 3'b111;
        tick(1);
        done = '0;
        tick(1);
        check("par2_valid", {5'b0, gnt_valid}, 8'h07);
        check("par2_sel",   {5'b0, gnt_sel},   8'h07);
        req = '0;
        tick(8);
        check("par_to_all", {5'b0, timeout}, 8'h07);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
